// File: rtl/reg_file_param.sv
// Parametrised register file with a per-register pending scoreboard for RAW stalls.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clock,
  input  logic                           resetN,
  input  logic                           regWrite,
  input  logic [ADDR_WIDTH-1:0]          writeRegister,
  input  logic [DATA_WIDTH-1:0]          writeData,
  input  logic                           reserveValid,
  input  logic [ADDR_WIDTH-1:0]          reserveRegister,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readRegister,
  output logic [NUM_READ*DATA_WIDTH-1:0] readData,
  output logic [NUM_READ-1:0]            readPending,
  output logic                           anyPending
);

  localparam bit ZERO_HARD = (ZERO_REG != 0);

  if (DEPTH < 2) begin : g_bad_depth
    $error("reg_file_param: DEPTH must be >= 2");
  end
  if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_addr
    $error("reg_file_param: ADDR_WIDTH too small for DEPTH");
  end
  if (NUM_READ < 1) begin : g_bad_ports
    $error("reg_file_param: NUM_READ must be >= 1");
  end

  // An address is usable when it maps to a real register that is not hardwired to zero.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    addr_ok = (32'(a) < 32'(DEPTH)) && !(ZERO_HARD && (a == '0));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      wr_hit;
  logic [DEPTH-1:0]      rsv_hit;
  logic                  wr_ok;
  logic                  rsv_ok;

  assign wr_ok  = regWrite && addr_ok(writeRegister);
  assign rsv_ok = reserveValid && addr_ok(reserveRegister);

  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (writeRegister == ADDR_WIDTH'(i)))
        wr_hit[i] = 1'b1;
      if (rsv_ok && (reserveRegister == ADDR_WIDTH'(i)))
        rsv_hit[i] = 1'b1;
    end
  end

  // A reserve in the same cycle as the writeback wins: it names a newer producer.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_hit[i])
          mem[i] <= writeData;
      pending <= (pending & ~wr_hit) | rsv_hit;
    end
  end

  assign anyPending = |pending;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  pend;

    assign addr = readRegister[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = '0;
      pend = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_ok(addr) && (addr == ADDR_WIDTH'(i))) begin
          data = mem[i];
          pend = pending[i];
        end
      end
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (addr == writeRegister)) begin
        data = writeData;
        pend = 1'b0;
      end
`endif
    end

    assign readData[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign readPending[k]                        = pend;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised register file for the datapath, replacing the fixed 32x32, two-read-port, write-on-strobe-edge register bank.
- Writes are synchronous to one clock. NUM_READ combinational read ports. Register 0 is optionally hardwired to zero.
- Holds a per-register pending scoreboard. Issue logic reserves a destination; writeback clears it. Read ports report pending so the control unit can stall on RAW hazards.

Parameters:
- DATA_WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; need not be a power of two; must be >= 2.
- ADDR_WIDTH, 5, address bits; must satisfy 2**ADDR_WIDTH >= DEPTH.
- NUM_READ, 2, number of read ports; must be >= 1.
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes, is never pending.

Ports:
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- regWrite  in  1  write enable, sampled on rising clock.
- writeRegister  in  ADDR_WIDTH  write address.
- writeData  in  DATA_WIDTH  write data.
- reserveValid  in  1  reserve request for a destination, sampled on rising clock.
- reserveRegister  in  ADDR_WIDTH  register to mark pending.
- readRegister  in  NUM_READ*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- readData  out  NUM_READ*DATA_WIDTH  read data, same packing.
- readPending  out  NUM_READ  bit k = addressed register pending.
- anyPending  out  1  OR of all pending bits.

Behaviour:
- Reset (resetN low, asynchronous, no clock needed):
  - All registers clear to 0; all pending bits clear.
  - readData is therefore all 0; readPending and anyPending are 0.
  - Deassertion takes effect at the next rising clock.
  - Reset asserted mid-write: the write is lost; the register stays 0.
- Write:
  - On rising clock with regWrite=1 and writeRegister < DEPTH, the register takes writeData.
  - The write is visible on readData one clock later (default, no bypass).
  - Write to address 0 with ZERO_REG=1 is discarded.
  - Write with address >= DEPTH is discarded; no aliasing.
- Read:
  - Purely combinational from the storage array and pending array.
  - Address >= DEPTH returns readData=0 and readPending=0.
  - Address 0 with ZERO_REG=1 always returns 0 and readPending=0.
  - All NUM_READ ports are independent; identical addresses are legal.
- Scoreboard, per register, on rising clock:
  - reserveValid=1 for register r sets pending[r].
  - regWrite=1 for register r clears pending[r].
  - Both on the same r in the same cycle: pending[r] = 1 (the reservation is a newer producer), and data is still written.
  - Both on different registers: both actions apply.
  - A reserve on an already-pending register keeps it 1; there is no count.
  - A write to a non-pending register is legal: data is written and pending stays 0.
  - Reserve of address 0 (ZERO_REG=1) or address >= DEPTH is ignored.
- anyPending: combinational OR of the pending array; used to drain before halt.
- No other state. Latency: write-to-read is 1 clock; reserve-to-readPending is 1 clock.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding. When regWrite=1 and a port's readRegister equals writeRegister (valid, non-zero-hardwired), readData returns writeData combinationally and readPending is forced 0.
  - Forwarding takes priority over a same-cycle reserve for readPending.
- Undefined:
  - No forwarding path; a read returns the stored value until the clock edge.
  - readPending reflects the stored pending bit only.
- Storage and scoreboard behaviour are identical in both builds.

Test Plan:
- Reset: assert resetN=0 between clock edges -> readData=0 and anyPending=0 immediately; release, write reg 5=0xDEADBEEF -> port0 reading 5 shows 0xDEADBEEF after 1 clock.
- Zero register: write reg 0=0x12345678 with ZERO_REG=1 -> read 0 returns 0. With ZERO_REG=0 -> read 0 returns 0x12345678.
- Scoreboard: reserve reg 7 -> readPending=1 next cycle. Write reg 7=0xA5 -> readPending=0 and readData=0xA5. Same-cycle reserve and write of reg 9 -> pending stays 1 and data is updated.
- Multi-port: NUM_READ=4, DEPTH=24, ADDR_WIDTH=5; fill regs 1..23 with value=index. Read 3, 3, 23, 30 -> 3, 3, 23, 0; write to 30 -> no register changes.
- Bypass (REG_FILE_BYPASS_EN): reg 4 holds 0x11; regWrite 4=0x22 while reading 4 -> 0x22 the same cycle. Without the macro -> 0x11, then 0x22 after the edge.
- Reset mid-write: resetN low coincident with a clock edge while writing reg 3=0xFF -> reg 3 reads 0 after release.
